// File: rtl/spi_pkg.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | spi_pkg : shared types and defaults for the SPI byte master         |
// | Revision: 1.0                                                       |
// +--------------------------------------------------------------------+
package spi_pkg;

    localparam int DATA_W_DEFAULT  = 8;
    localparam int CLK_DIV_DEFAULT = 4;
    localparam int HALF_CNT_W      = 8;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SETUP = 2'd1,
        SHIFT = 2'd2,
        HOLD  = 2'd3
    } spi_state_t;

endpackage
`default_nettype wire

// File: rtl/spi_sclk_div.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | spi_sclk_div : half-period counter with alternating rise/fall      |
// | strobes, one cycle wide, while enabled.   Revision: 1.0            |
// +--------------------------------------------------------------------+
module spi_sclk_div
    import spi_pkg::*;
#(
    parameter int CLK_DIV = CLK_DIV_DEFAULT
) (
    input  logic clk,
    input  logic rst,
    input  logic en,
    output logic rise,
    output logic fall
);

    localparam logic [HALF_CNT_W-1:0] RELOAD = HALF_CNT_W'(CLK_DIV - 1);

    logic [HALF_CNT_W-1:0] half_cnt;
    logic                  phase;
    logic                  tick;

    assign tick = en && (half_cnt == '0);
    assign rise = tick && !phase;
    assign fall = tick && phase;

    // Held at RELOAD while disabled so the first phase after enable is full length.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            half_cnt <= '0;
            phase    <= 1'b0;
        end else if (!en) begin
            half_cnt <= RELOAD;
            phase    <= 1'b0;
        end else if (tick) begin
            half_cnt <= RELOAD;
            phase    <= ~phase;
        end else begin
            half_cnt <= half_cnt - 1'b1;
        end
    end

endmodule
`default_nettype wire

// File: rtl/spi_byte_master.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | spi_byte_master : mode-0 SPI master, one DATA_W-bit word per        |
// | transfer, MSB first, all outputs registered.   Revision: 1.0       |
// +--------------------------------------------------------------------+
module spi_byte_master
    import spi_pkg::*;
#(
    parameter int CLK_DIV = CLK_DIV_DEFAULT,
    parameter int DATA_W  = DATA_W_DEFAULT
) (
    input  logic              clk_out1,
    input  logic              reset,
    input  logic [DATA_W-1:0] tx_data,
    input  logic              tx_valid,
    output logic              tx_ready,
    output logic [DATA_W-1:0] rx_data,
    output logic              rx_valid,
    output logic              busy,
    output logic              sclk,
    output logic              mosi,
    input  logic              miso,
    output logic              cs_n
);

    localparam int              BIT_W    = $clog2(DATA_W) + 1;
    localparam logic [BIT_W-1:0] LAST_BIT = BIT_W'(DATA_W - 1);
    localparam logic [BIT_W-1:0] ALL_BITS = BIT_W'(DATA_W);

    spi_state_t        state, state_d;
    logic [DATA_W-1:0] tx_sr, tx_sr_d;
    logic [DATA_W-1:0] rx_sr, rx_sr_d;
    logic [BIT_W-1:0]  bit_cnt, bit_cnt_d;
    logic [DATA_W-1:0] rx_data_d;
    logic              rx_valid_d, busy_d, sclk_d, mosi_d, cs_n_d, tx_ready_d;
    logic              div_en, div_rise, div_fall, tick;

    assign div_en = (state != IDLE);
    assign tick   = div_rise || div_fall;

    spi_sclk_div #(
        .CLK_DIV (CLK_DIV)
    ) u_sclk_div (
        .clk  (clk_out1),
        .rst  (reset),
        .en   (div_en),
        .rise (div_rise),
        .fall (div_fall)
    );

    always_ff @(posedge clk_out1 or posedge reset) begin
        if (reset) begin
            state    <= IDLE;
            tx_sr    <= '0;
            rx_sr    <= '0;
            bit_cnt  <= '0;
            rx_data  <= '0;
            rx_valid <= 1'b0;
            busy     <= 1'b0;
            sclk     <= 1'b0;
            mosi     <= 1'b0;
            cs_n     <= 1'b1;
            tx_ready <= 1'b1;
        end else begin
            state    <= state_d;
            tx_sr    <= tx_sr_d;
            rx_sr    <= rx_sr_d;
            bit_cnt  <= bit_cnt_d;
            rx_data  <= rx_data_d;
            rx_valid <= rx_valid_d;
            busy     <= busy_d;
            sclk     <= sclk_d;
            mosi     <= mosi_d;
            cs_n     <= cs_n_d;
            tx_ready <= tx_ready_d;
        end
    end

    always_comb begin
        state_d    = state;
        tx_sr_d    = tx_sr;
        rx_sr_d    = rx_sr;
        bit_cnt_d  = bit_cnt;
        rx_data_d  = rx_data;
        rx_valid_d = 1'b0;
        busy_d     = busy;
        sclk_d     = sclk;
        mosi_d     = mosi;
        cs_n_d     = cs_n;
        tx_ready_d = tx_ready;

        case (state)
            IDLE: begin
                if (tx_valid && tx_ready) begin
                    state_d    = SETUP;
                    tx_sr_d    = tx_data;
                    mosi_d     = tx_data[DATA_W-1];
                    cs_n_d     = 1'b0;
                    busy_d     = 1'b1;
                    tx_ready_d = 1'b0;
                    sclk_d     = 1'b0;
                    bit_cnt_d  = '0;
                end
            end
            SETUP: begin
                if (tick) begin
                    state_d = SHIFT;
                    sclk_d  = 1'b1;
                    rx_sr_d = (rx_sr << 1) | DATA_W'(miso);
                end
            end
            SHIFT: begin
                // bit_cnt counts falling edges; the low phase after the last one stays in SHIFT
                if (tick) begin
                    if (sclk) begin
                        sclk_d    = 1'b0;
                        bit_cnt_d = bit_cnt + 1'b1;
                        if (bit_cnt != LAST_BIT) begin
                            tx_sr_d = tx_sr << 1;
                            mosi_d  = tx_sr_d[DATA_W-1];
                        end
                    end else if (bit_cnt == ALL_BITS) begin
                        state_d = HOLD;
                    end else begin
                        sclk_d  = 1'b1;
                        rx_sr_d = (rx_sr << 1) | DATA_W'(miso);
                    end
                end
            end
            HOLD: begin
                if (tick) begin
                    state_d    = IDLE;
                    cs_n_d     = 1'b1;
                    busy_d     = 1'b0;
                    tx_ready_d = 1'b1;
                    rx_valid_d = 1'b1;
                    rx_data_d  = rx_sr;
                end
            end
            default: state_d = IDLE;
        endcase
    end

endmodule
`default_nettype wire

// File: doc/spi_byte_master.md
SPI_BYTE_MASTER -- requirements
Module: spi_byte_master

Interface
Parameters:
REQ-001 The block SHALL have parameter CLK_DIV, default 4, giving the SCLK half-period in clk_out1 cycles; legal range 2..255.
REQ-002 The block SHALL have parameter DATA_W, default 8, giving the bits per transfer.

Ports:
REQ-003 The block SHALL have one clock and an asynchronous, active-high reset, with ports clk_out1 and reset as listed below.
REQ-004 clk_out1  input  1  system clock from the clock wizard; all state changes on its rising edge.
REQ-005 reset  input  1  asynchronous, active-high reset.
REQ-006 tx_data  input  DATA_W  byte to send, MSB first.
REQ-007 tx_valid  input  1  tx_data is valid.
REQ-008 tx_ready  output  1  block can accept a byte.
REQ-009 rx_data  output  DATA_W  byte captured from miso.
REQ-010 rx_valid  output  1  one-cycle strobe: rx_data is valid.
REQ-011 busy  output  1  a transfer is in progress.
REQ-012 sclk  output  1  SPI clock, mode 0 (CPOL=0, CPHA=0).
REQ-013 mosi  output  1  serial data out.
REQ-014 miso  input  1  serial data in.
REQ-015 cs_n  output  1  active-low chip select.

Function
REQ-016 All outputs SHALL be registered.
REQ-017 The state machine SHALL have four states, IDLE, SETUP, SHIFT and HOLD, with only the transitions IDLE->SETUP->SHIFT->HOLD->IDLE.
REQ-018 tx_ready SHALL be 1 only in IDLE; a byte is accepted on a clk_out1 edge where tx_valid and tx_ready are both 1.
REQ-019 On acceptance, tx_data SHALL be latched into the shift register, cs_n SHALL go 0, mosi SHALL take tx_data[DATA_W-1], busy SHALL go 1, and the state SHALL become SETUP; all of these are visible in the next cycle.
REQ-020 The block SHALL stay in SETUP for CLK_DIV cycles with sclk=0, then go to SHIFT and drive sclk to 1.
REQ-021 In SHIFT, sclk SHALL toggle every CLK_DIV cycles, giving an SCLK period of 2*CLK_DIV cycles and exactly DATA_W rising edges.
REQ-022 On each clk_out1 edge that drives sclk 0->1, the block SHALL shift miso into the LSB of the receive register.
REQ-023 On each clk_out1 edge that drives sclk 1->0, except the last, mosi SHALL advance to the next lower bit.
REQ-024 After the DATA_W-th falling edge of sclk, the block SHALL enter HOLD for CLK_DIV cycles with cs_n=0, sclk=0 and mosi held at bit 0.
REQ-025 On the cycle HOLD exits, cs_n SHALL go 1, busy SHALL go 0, rx_data SHALL be updated, rx_valid SHALL be 1 for exactly one cycle, and the state SHALL become IDLE.
REQ-026 The time from acceptance to cs_n rising SHALL be (2*DATA_W+2)*CLK_DIV cycles; this is 72 cycles at the defaults.
REQ-027 cs_n SHALL stay 1 for at least one cycle between transfers, even when tx_valid is held high.
REQ-028 tx_valid and tx_data SHALL be ignored while busy=1, and the transfer in progress SHALL be unaffected.
REQ-029 rx_data SHALL hold its value until the next rx_valid.
REQ-030 The half-period counter SHALL be 8 bits wide and count from CLK_DIV-1 down to 0; reaching 0 triggers the phase event and reloads the counter.
REQ-031 The bit counter SHALL be $clog2(DATA_W)+1 bits wide and SHALL never wrap during a transfer.

Reset
REQ-032 While reset=1, the block SHALL be in IDLE with cs_n=1, sclk=0, mosi=0, tx_ready=1, busy=0, rx_valid=0 and rx_data=0, and all counters cleared.
REQ-033 Reset asserted mid-transfer SHALL abort the transfer immediately: cs_n goes 1 asynchronously, and no rx_valid pulse is produced.
REQ-034 After reset is released, the first accepted byte SHALL start a clean transfer.

Structure
REQ-035 Package spi_pkg SHALL hold the state enum (IDLE, SETUP, SHIFT, HOLD), DATA_W_DEFAULT=8 and CLK_DIV_DEFAULT=4.
REQ-036 The natural sub-module is spi_sclk_div: a half-period counter emitting one-cycle rise and fall strobes while enabled.
REQ-037 The shift/receive registers and the state machine SHALL remain in the top module.

Verification
REQ-038 Loopback (miso=mosi), tx_data=0xA5 -> rx_data=0xA5, rx_valid high for exactly one cycle, and 8 sclk rising edges while cs_n=0.
REQ-039 miso tied to 1, tx_data=0x00 -> rx_data=0xFF; mosi stays 0 for the whole transfer.
REQ-040 CLK_DIV=2, tx_data=0x3C -> cs_n low for exactly 36 cycles; each sclk high and low phase lasts 2 cycles.
REQ-041 tx_valid held high with tx_data 0x12 then 0x34 -> two transfers, cs_n high for at least 1 cycle between them, loopback rx_data 0x12 then 0x34; tx_data changed mid-transfer does not alter mosi.
REQ-042 Reset pulsed after the 3rd sclk rise of 0xFF -> cs_n=1 and sclk=0 immediately, no rx_valid; a following 0x81 completes with loopback rx_data=0x81.
